// File: rtl/memory_arbiter.sv
// memory_arbiter
//
// Puts instruction fetches and data reads/writes onto a single RAM port, one
// access at a time. Each completed access gives a one-cycle ihit/dhit pulse
// and the registered read word on iload/dload. These hit pulses drive the
// hazard unit's pipeline enables and flushes.
//
// When both sides are waiting in IDLE, the arbiter grants the side that was
// not served last. A sticky timeout_err flag records any access that waited
// TIMEOUT or more cycles without the RAM answering ACCESS.
//
// Ports
//   CLK          system clock, rising edge
//   nRST         asynchronous active-low reset
//   iREN, iaddr  instruction read request, held until ihit
//   dREN, dWEN   data read / write request, held until dhit
//   daddr        data address
//   dstore       data write value
//   ramstate     RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   ramload      RAM read data, valid when ramstate is ACCESS
//   ramREN       RAM read strobe
//   ramWEN       RAM write strobe
//   ramaddr      RAM address
//   ramstore     RAM write data
//   ihit, dhit   one-cycle access-complete pulses
//   iload        last instruction word read
//   dload        last data word read
//   timeout_err  sticky access timeout flag, cleared only by reset
//
// state | meaning
// IDLE  | no access in flight, arbitrating pending requests
// IACC  | instruction read presented to RAM, waiting for ACCESS
// DACC  | data read/write presented to RAM, waiting for ACCESS
// HIT   | hit pulse for the access just completed, requests ignored
module memory_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        HIT  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          last_grant;   // 1: data was served last, 0: instruction
    logic [31:0]   req_addr;
    logic [31:0]   req_store;
    logic          req_wr;
    logic [CW-1:0] wait_cnt;
    logic          grant_i;
    logic          grant_d;
    logic          in_acc;
    logic          ram_done;

    assign in_acc   = (state == IACC) || (state == DACC);
    assign ram_done = (ramstate == RAM_ACCESS);

    // Arbitration and next state
    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (iREN && (dREN || dWEN)) begin
                    if (last_grant) grant_i = 1'b1;
                    else            grant_d = 1'b1;
                end else if (iREN) begin
                    grant_i = 1'b1;
                end else if (dREN || dWEN) begin
                    grant_d = 1'b1;
                end
                if (grant_i)      next_state = IACC;
                else if (grant_d) next_state = DACC;
            end
            IACC, DACC: begin
                if (ram_done) next_state = HIT;
            end
            HIT: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes and hits are decoded from state so that reset drops them
    // immediately.
    always_comb begin
        ramREN   = in_acc && !req_wr;
        ramWEN   = in_acc && req_wr;
        ramaddr  = in_acc ? req_addr : 32'd0;
        ramstore = in_acc ? req_store : 32'd0;
        ihit     = (state == HIT) && !last_grant;
        dhit     = (state == HIT) && last_grant;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant  <= 1'b0;
            req_addr    <= 32'd0;
            req_store   <= 32'd0;
            req_wr      <= 1'b0;
            wait_cnt    <= '0;
            iload       <= 32'd0;
            dload       <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_i) begin
                req_addr   <= iaddr;
                req_store  <= 32'd0;
                req_wr     <= 1'b0;
                last_grant <= 1'b0;
                wait_cnt   <= '0;
            end else if (grant_d) begin
                req_addr   <= daddr;
                req_store  <= dstore;
                req_wr     <= dWEN;    // a write wins over a simultaneous read
                last_grant <= 1'b1;
                wait_cnt   <= '0;
            end else if (in_acc) begin
                if (ram_done) begin
                    if (state == IACC)  iload <= ramload;
                    else if (!req_wr)   dload <= ramload;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + CNT_ONE;
                end
            end

            // The flag is registered, so it rises one cycle after the
            // counter saturates.
            if (wait_cnt == CNT_MAX) timeout_err <= 1'b1;
        end
    end

endmodule
